// File: rtl/direction_queue.sv
// Direction request queue: edge-detects one-hot key requests, filters reversals/duplicates
// and hands one turn to the datapath per move tick. DIR_QUEUE_DROP_CNT_EN adds drop_count.
module direction_queue #(
  parameter int         DEPTH    = 4,
  parameter int         CNT_W    = 3,
  parameter logic [4:0] INIT_DIR = 5'b10000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic [4:0]       dir_in,
  input  logic             move_tick,
  output logic [4:0]       direction,
  output logic             dir_changed,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
`ifdef DIR_QUEUE_DROP_CNT_EN
  output logic [7:0]       drop_count,
`endif
  output logic             drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // UP<->DOWN (bit1<->bit3), LEFT<->RIGHT (bit2<->bit4)
  function automatic logic [4:0] opposite(input logic [4:0] d);
    return {d[2], d[1], d[4], d[3], 1'b0};
  endfunction

  logic [4:0]       mem [DEPTH];
  logic [4:0]       prev_in_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;

  logic             legal_code;
  logic             request;
  logic             accept;
  logic [4:0]       ref_dir;
  logic             push;
  logic             pop;
  logic             drop_next;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    legal_code = (dir_in == 5'b00010) || (dir_in == 5'b00100) ||
                 (dir_in == 5'b01000) || (dir_in == 5'b10000);
    request    = legal_code && (dir_in != prev_in_reg);
    // Compare against the newest queued turn so queued sequences stay self-consistent
    ref_dir    = empty ? direction : mem[wr_ptr_reg - PTR_W'(1)];
    accept     = request && (dir_in != ref_dir) && (dir_in != opposite(ref_dir));
    pop        = !clear && move_tick && !empty;
    push       = !clear && accept && (!full || pop);
    drop_next  = !clear && accept && full && !pop;
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (pop && !push)
      count_next = count - CNT_W'(1);
  end

  // Storage needs no reset: the pointers define which entries are valid
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= dir_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_in_reg <= 5'b00000;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      direction   <= INIT_DIR;
      dir_changed <= 1'b0;
      drop        <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      prev_in_reg <= dir_in;
      dir_changed <= pop;
      drop        <= drop_next;
      if (clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        direction  <= INIT_DIR;
        count      <= '0;
        full       <= 1'b0;
        empty      <= 1'b1;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          direction  <= mem[rd_ptr_reg];
        end
        count <= count_next;
        full  <= (count_next == CNT_W'(DEPTH));
        empty <= (count_next == '0);
      end
    end
  end

`ifdef DIR_QUEUE_DROP_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      drop_count <= 8'd0;
    else if (clear)
      drop_count <= 8'd0;
    else if (drop_next && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_direction_queue.sv
// Self-checking bench for direction_queue: queued turns are scoreboarded and compared
// against direction each time dir_changed pulses.
module tb_direction_queue;

  localparam logic [4:0] UP    = 5'b00010;
  localparam logic [4:0] LEFT  = 5'b00100;
  localparam logic [4:0] DOWN  = 5'b01000;
  localparam logic [4:0] RIGHT = 5'b10000;
  localparam logic [4:0] NONE  = 5'b00000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clear;
  logic [4:0] dir_in;
  logic       move_tick;
  logic [4:0] direction;
  logic       dir_changed;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       drop;
`ifdef DIR_QUEUE_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [4:0] sb [$];

  direction_queue dut (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (clear),
    .dir_in      (dir_in),
    .move_tick   (move_tick),
    .direction   (direction),
    .dir_changed (dir_changed),
    .count       (count),
    .full        (full),
    .empty       (empty),
`ifdef DIR_QUEUE_DROP_CNT_EN
    .drop_count  (drop_count),
`endif
    .drop        (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else
      $display("ok   %s: %0h", tag, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] d);
    dir_in = d;
    tick();
    dir_in = NONE;
    tick();
  endtask

  task automatic move();
    move_tick = 1'b1;
    tick();
    move_tick = 1'b0;
    tick();
  endtask

  // Each dir_changed pulse consumes the oldest expected turn
  always begin
    @(posedge clk);
    #1;
    if (resetn && dir_changed) begin
      if (sb.size() == 0)
        check("dir_changed_unexpected", 32'd1, 32'd0);
      else
        check("pop_direction", {27'd0, direction}, {27'd0, sb.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; clear = 1'b0; dir_in = NONE; move_tick = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check("reset_direction", {27'd0, direction}, {27'd0, RIGHT});
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_full", {31'd0, full}, 32'd0);
    check("reset_count", {29'd0, count}, 32'd0);

    // Ticks on an empty queue change nothing
    for (int i = 0; i < 3; i++) begin
      move_tick = 1'b1;
      tick();
      move_tick = 1'b0;
      check("idle_tick_dir_changed", {31'd0, dir_changed}, 32'd0);
      check("idle_tick_direction", {27'd0, direction}, {27'd0, RIGHT});
      tick();
    end
    check("idle_count", {29'd0, count}, 32'd0);

    // Held key enqueues exactly once
    dir_in = UP;
    sb.push_back(UP);
    tick();
    check("held_count_first", {29'd0, count}, 32'd1);
    repeat (19) tick();
    check("held_count_last", {29'd0, count}, 32'd1);
    dir_in = NONE;
    move_tick = 1'b1;
    tick();
    move_tick = 1'b0;
    check("held_pop_pulse", {31'd0, dir_changed}, 32'd1);
    check("held_pop_count", {29'd0, count}, 32'd0);
    tick();
    check("held_pulse_one_cycle", {31'd0, dir_changed}, 32'd0);
    check("held_direction", {27'd0, direction}, {27'd0, UP});

    // Reversal and duplicate filtering from RIGHT
    clear = 1'b1; tick(); clear = 1'b0; tick();
    check("clear_direction", {27'd0, direction}, {27'd0, RIGHT});
    press(LEFT);
    check("reversal_rejected", {29'd0, count}, 32'd0);
    check("reversal_no_drop", {31'd0, drop}, 32'd0);
    press(DOWN);
    sb.push_back(DOWN);
    check("down_queued", {29'd0, count}, 32'd1);
    press(DOWN);
    check("duplicate_rejected", {29'd0, count}, 32'd1);
    move();
    check("down_popped", {27'd0, direction}, {27'd0, DOWN});

    // Fill to DEPTH, then overflow
    clear = 1'b1; tick(); clear = 1'b0; tick();
    press(UP); press(LEFT); press(DOWN); press(RIGHT);
    sb.push_back(UP); sb.push_back(LEFT); sb.push_back(DOWN); sb.push_back(RIGHT);
    check("fill_count", {29'd0, count}, 32'd4);
    check("fill_full", {31'd0, full}, 32'd1);
    dir_in = UP;
    tick();
    check("overflow_drop", {31'd0, drop}, 32'd1);
    check("overflow_count", {29'd0, count}, 32'd4);
`ifdef DIR_QUEUE_DROP_CNT_EN
    check("overflow_drop_count", {24'd0, drop_count}, 32'd1);
`endif
    dir_in = NONE;
    tick();
    check("drop_one_cycle", {31'd0, drop}, 32'd0);
    repeat (4) move();
    check("drained_empty", {31'd0, empty}, 32'd1);
    check("drained_direction", {27'd0, direction}, {27'd0, RIGHT});

    // Full queue with simultaneous push and pop
    press(UP); press(LEFT); press(DOWN); press(RIGHT);
    sb.push_back(UP); sb.push_back(LEFT); sb.push_back(DOWN); sb.push_back(RIGHT);
    sb.push_back(UP);
    dir_in = UP;
    move_tick = 1'b1;
    tick();
    move_tick = 1'b0;
    dir_in = NONE;
    check("pushpop_no_drop", {31'd0, drop}, 32'd0);
    check("pushpop_count", {29'd0, count}, 32'd4);
    check("pushpop_full", {31'd0, full}, 32'd1);
    tick();
    repeat (4) move();
    check("pushpop_last", {27'd0, direction}, {27'd0, UP});
    check("pushpop_empty", {31'd0, empty}, 32'd1);

    // Clear concurrent with move_tick on a two-entry queue
    press(LEFT); press(DOWN);
    check("two_entries", {29'd0, count}, 32'd2);
    clear = 1'b1;
    move_tick = 1'b1;
    tick();
    clear = 1'b0;
    move_tick = 1'b0;
    sb.delete();
    check("clear_count", {29'd0, count}, 32'd0);
    check("clear_dir", {27'd0, direction}, {27'd0, RIGHT});
    check("clear_no_dir_changed", {31'd0, dir_changed}, 32'd0);
    tick();

    // Asynchronous reset mid-stream
    press(UP);
    sb.push_back(UP);
    move_tick = 1'b1;
    tick();
    move_tick = 1'b0;
    press(LEFT);
    check("pre_reset_count", {29'd0, count}, 32'd1);
    #2;
    resetn = 1'b0;
    sb.delete();
    #1;
    check("async_direction", {27'd0, direction}, {27'd0, RIGHT});
    check("async_count", {29'd0, count}, 32'd0);
    check("async_empty", {31'd0, empty}, 32'd1);
    check("async_full", {31'd0, full}, 32'd0);
    check("async_dir_changed", {31'd0, dir_changed}, 32'd0);
    check("async_drop", {31'd0, drop}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
